// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - opcode constants, ALU class encoding and control bundle for the main decoder
package controller_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RTYPE  = 2'b10,
        ALU_ITYPE  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    alu_src;
        logic    mem2reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

    // A bubble carries no register or memory side effects.
    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic ctrl_t make_ctrl(input logic alu_src, input logic mem2reg,
                                        input logic reg_write, input logic mem_read,
                                        input logic mem_write, input logic branch,
                                        input logic jump, input alu_op_e alu_op);
        ctrl_t c;
        c.alu_src   = alu_src;
        c.mem2reg   = mem2reg;
        c.reg_write = reg_write;
        c.mem_read  = mem_read;
        c.mem_write = mem_write;
        c.branch    = branch;
        c.jump      = jump;
        c.alu_op    = alu_op;
        return c;
    endfunction

endpackage

// File: rtl/controller_if.sv
// rtl/controller_if.sv - decode request/control bundle interface (illegal present with CONTROLLER_ILLEGAL_EN)
interface controller_if;

    logic       stall;
    logic       flush;
    logic [6:0] opcode;
    logic       ALUSrc;
    logic       mem2Reg;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       jump;
    logic [1:0] ALUOp;
`ifdef CONTROLLER_ILLEGAL_EN
    logic       illegal;
`endif

    modport master (
        output stall, flush, opcode,
        input  ALUSrc, mem2Reg, regWrite, memRead, memWrite, branch, jump, ALUOp
`ifdef CONTROLLER_ILLEGAL_EN
        , input illegal
`endif
    );

    modport slave (
        input  stall, flush, opcode,
        output ALUSrc, mem2Reg, regWrite, memRead, memWrite, branch, jump, ALUOp
`ifdef CONTROLLER_ILLEGAL_EN
        , output illegal
`endif
    );

endinterface

// File: rtl/controller_decode.sv
// rtl/controller_decode.sv - combinational opcode to control bundle decode (CONTROLLER_ILLEGAL_EN adds illegal flag)
module controller_decode
    import controller_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl
`ifdef CONTROLLER_ILLEGAL_EN
    , output logic     illegal
`endif
);

    // Map each supported opcode to its control row; anything else becomes a bubble.
    always_comb begin
        ctrl = CTRL_BUBBLE;
`ifdef CONTROLLER_ILLEGAL_EN
        illegal = 1'b0;
`endif
        case (opcode)
            OP_RTYPE:  ctrl = make_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_RTYPE);
            OP_ITYPE:  ctrl = make_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ITYPE);
            OP_LOAD:   ctrl = make_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD);
            OP_STORE:  ctrl = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_ADD);
            OP_BRANCH: ctrl = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_BRANCH);
            OP_JAL:    ctrl = make_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
            OP_JALR:   ctrl = make_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
            default: begin
                ctrl = CTRL_BUBBLE;
`ifdef CONTROLLER_ILLEGAL_EN
                illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/controller.sv
// rtl/controller.sv - registered ID/EX control decode with reset/flush/stall priority (optional CONTROLLER_ILLEGAL_EN)
module controller
    import controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    controller_if.slave bus
);

    ctrl_t dec_ctrl;
    ctrl_t ctrl_q;
`ifdef CONTROLLER_ILLEGAL_EN
    logic  dec_illegal;
    logic  illegal_q;
`endif

    controller_decode u_decode (
        .opcode  (bus.opcode),
        .ctrl    (dec_ctrl)
`ifdef CONTROLLER_ILLEGAL_EN
        , .illegal (dec_illegal)
`endif
    );

    // ID/EX control register: reset beats flush beats stall beats a fresh decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= CTRL_BUBBLE;
        end else if (bus.flush) begin
            ctrl_q <= CTRL_BUBBLE;
        end else if (!bus.stall) begin
            ctrl_q <= dec_ctrl;
        end
    end

`ifdef CONTROLLER_ILLEGAL_EN
    // Illegal flag travels alongside the control bundle with the same priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (bus.flush) begin
            illegal_q <= 1'b0;
        end else if (!bus.stall) begin
            illegal_q <= dec_illegal;
        end
    end

    assign bus.illegal = illegal_q;
`endif

    assign bus.ALUSrc   = ctrl_q.alu_src;
    assign bus.mem2Reg  = ctrl_q.mem2reg;
    assign bus.regWrite = ctrl_q.reg_write;
    assign bus.memRead  = ctrl_q.mem_read;
    assign bus.memWrite = ctrl_q.mem_write;
    assign bus.branch   = ctrl_q.branch;
    assign bus.jump     = ctrl_q.jump;
    assign bus.ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - self-checking bench for controller against a table-driven pipeline register model
module tb_controller;

    logic clk;
    logic reset;

    controller_if bus ();

    controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode table rows: ALUSrc,mem2Reg,regWrite,memRead,memWrite,branch,jump,ALUOp
    logic [6:0] tbl_op  [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111};
    logic [8:0] tbl_row [7] = '{9'b0_0_1_0_0_0_0_10, 9'b1_0_1_0_0_0_0_11,
                                9'b1_1_1_1_0_0_0_00, 9'b1_0_0_0_1_0_0_00,
                                9'b0_0_0_0_0_1_0_01, 9'b0_0_1_0_0_0_1_00,
                                9'b1_0_1_0_0_0_1_00};

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] exp_ctrl = '0;
    logic       exp_ill  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [9:0] ref_decode(input logic [6:0] op);
        for (int i = 0; i < 7; i++)
            if (tbl_op[i] == op) return {1'b0, tbl_row[i]};
        return {1'b1, 9'b0};
    endfunction

    function automatic logic [8:0] observed();
        return {bus.ALUSrc, bus.mem2Reg, bus.regWrite, bus.memRead, bus.memWrite,
                bus.branch, bus.jump, bus.ALUOp};
    endfunction

    // Apply one cycle of inputs, advance the model, compare just after the edge.
    task automatic step(input logic r, input logic f, input logic s,
                        input logic [6:0] op, input string tag);
        logic [9:0] d;
        reset      = r;
        bus.flush  = f;
        bus.stall  = s;
        bus.opcode = op;
        @(posedge clk);
        #1;
        d = ref_decode(op);
        if (r || f) begin
            exp_ctrl = '0;
            exp_ill  = 1'b0;
        end else if (!s) begin
            exp_ctrl = d[8:0];
            exp_ill  = d[9];
        end
        check(tag, {23'b0, observed()}, {23'b0, exp_ctrl});
`ifdef CONTROLLER_ILLEGAL_EN
        check({tag, "_illegal"}, {31'b0, bus.illegal}, {31'b0, exp_ill});
`endif
    endtask

    initial begin
        logic r, f, s;
        logic [6:0] op;
        reset      = 1'b1;
        bus.flush  = 1'b0;
        bus.stall  = 1'b0;
        bus.opcode = 7'b0110011;

        step(1, 0, 0, 7'b0110011, "reset_hold0");
        step(1, 0, 0, 7'b0110011, "reset_hold1");
        check("reset_zero", {23'b0, observed()}, 32'h0);
        step(0, 0, 0, 7'b0110011, "first_rtype");
        check("first_rtype_row", {23'b0, observed()}, {23'b0, 9'b0_0_1_0_0_0_0_10});

        step(0, 0, 0, 7'b1100011, "sweep_branch");
        step(0, 0, 0, 7'b0110011, "sweep_rtype");
        step(0, 0, 0, 7'b0010011, "sweep_itype");
        step(0, 0, 0, 7'b0000011, "sweep_load");
        step(0, 0, 0, 7'b0100011, "sweep_store");
        step(0, 0, 0, 7'b1101111, "sweep_jal");
        step(0, 0, 0, 7'b1100111, "sweep_jalr");

        step(0, 0, 0, 7'b0100101, "unknown_op");
        step(0, 0, 0, 7'b0000000, "zero_op");

        step(0, 0, 0, 7'b0000011, "stall_load");
        step(0, 0, 1, 7'b0100011, "stall_hold0");
        step(0, 0, 1, 7'b0100011, "stall_hold1");
        check("stall_load_row", {23'b0, observed()}, {23'b0, 9'b1_1_1_1_0_0_0_00});
        step(0, 0, 0, 7'b0100011, "stall_release");

        step(0, 1, 1, 7'b1101111, "flush_stall");
        check("flush_zero", {23'b0, observed()}, 32'h0);

        step(0, 0, 0, 7'b1100111, "pre_reset_jalr");
        step(1, 0, 0, 7'b0000011, "mid_reset");
        step(0, 0, 0, 7'b0000011, "resume_load");

        for (int k = 0; k < 400; k++) begin
            r  = ($urandom_range(0, 24) == 0);
            f  = ($urandom_range(0, 9) == 0);
            s  = ($urandom_range(0, 4) == 0);
            op = ($urandom_range(0, 3) != 0) ? tbl_op[$urandom_range(0, 6)] : 7'($urandom);
            step(r, f, s, op, "random");
            check("inv_mem", {31'b0, bus.memRead & bus.memWrite}, 32'h0);
            check("inv_jump", {31'b0, bus.jump & bus.branch}, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
